alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_pkg.sv | 19 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/alu_sched.sv | 179 +++++++++++++++++
 tb/tb_alu_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU request scheduler.
// Opcodes with sel[2] set are invalid and are flagged by the external ALU.
package alu_pkg;

  localparam int unsigned ALU_DW = 2;
  localparam int unsigned ALU_SW = 3;

  localparam logic [ALU_SW-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_SW-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_SW-1:0] OP_AND = 3'b010;
  localparam logic [ALU_SW-1:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant.
// The pointer favours req0 after reset and moves only when advance is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr_q = 0 favours req0, ptr_q = 1 favours req1
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || !ptr_q)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  // After granting one requester, the other one gets priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules two requester channels onto one external combinational ALU.
// IDLE accepts a granted request, EXEC captures ALU results, RESP holds them.
module alu_sched
  import alu_pkg::*;
#(
  parameter int unsigned DW  = ALU_DW,
  parameter int unsigned SW  = ALU_SW,
  parameter int unsigned ECW = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [SW-1:0] req0_sel,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [SW-1:0] req1_sel,

  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  input  logic          alu_error,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_out,
  output logic          rsp_zero,
  output logic          rsp_carry,
  output logic          rsp_overflow,
  output logic          rsp_error,

  output logic [ECW-1:0] err_count
);

  state_e         state_q,     state_d;
  logic           ready_en_q,  ready_en_d;
  logic [DW-1:0]  alu_a_q,     alu_a_d;
  logic [DW-1:0]  alu_b_q,     alu_b_d;
  logic [SW-1:0]  alu_sel_q,   alu_sel_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q,    rsp_id_d;
  logic [DW-1:0]  rsp_out_q,   rsp_out_d;
  logic           rsp_zero_q,  rsp_zero_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_ovf_q,   rsp_ovf_d;
  logic           rsp_err_q,   rsp_err_d;
  logic [ECW-1:0] err_count_q, err_count_d;

  logic [1:0]     arb_req;
  logic [1:0]     gnt;
  logic           xfer;

  // Requests reach the arbiter only in IDLE, and never in the first cycle
  // after reset release, so the grant doubles as the ready vector.
  always_comb begin
    arb_req = '0;
    if ((state_q == ST_IDLE) && ready_en_q) begin
      arb_req = {req1_valid, req0_valid};
    end
  end

  assign xfer = |gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (xfer),
    .gnt     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    ready_en_d  = 1'b1;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_carry_d = rsp_carry_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          alu_a_d   = gnt[1] ? req1_a   : req0_a;
          alu_b_d   = gnt[1] ? req1_b   : req0_b;
          alu_sel_d = gnt[1] ? req1_sel : req0_sel;
          rsp_id_d  = gnt[1];
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_out_d   = alu_out;
        rsp_zero_d  = alu_zero;
        rsp_carry_d = alu_carry;
        rsp_ovf_d   = alu_overflow;
        rsp_err_d   = alu_error;
        rsp_valid_d = 1'b1;
        if (alu_error && (err_count_q != '1)) begin
          err_count_d = err_count_q + 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_en_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign req0_ready   = gnt[0];
  assign req1_ready   = gnt[1];
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_out      = rsp_out_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_error    = rsp_err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small 2-bit ALU model on the alu_* ports.
module tb_alu_sched;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic [1:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_zero, alu_carry, alu_overflow, alu_error;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [1:0] rsp_out;
  logic       rsp_zero, rsp_carry, rsp_overflow, rsp_error;
  logic [3:0] err_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [2:0]  sum;

  always #5 clk = ~clk;

  alu_sched #(.DW(2), .SW(3), .ECW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
    .err_count(err_count)
  );

  // External ALU: carry is the carry-out on ADD and the borrow on SUB.
  always_comb begin
    sum          = '0;
    alu_out      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_error    = 1'b0;
    unique case (alu_sel)
      OP_ADD: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = sum[1:0];
        alu_carry    = sum[2];
        alu_overflow = (alu_a[1] == alu_b[1]) && (sum[1] != alu_a[1]);
      end
      OP_SUB: begin
        sum          = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out      = sum[1:0];
        alu_carry    = sum[2];
        alu_overflow = (alu_a[1] != alu_b[1]) && (sum[1] != alu_a[1]);
      end
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      default: alu_error = 1'b1;
    endcase
    alu_zero = (alu_out == 2'b00) && !alu_error;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp_ready = 1'b0;

    // Reset state, with req0 already requesting ADD 01+01
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 2'b01; req0_b = 2'b01; req0_sel = OP_ADD;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_sel", 32'(alu_sel), 0);
    chk("rst_rsp_out", 32'(rsp_out), 0);
    chk("rst_err_count", 32'(err_count), 0);

    @(negedge clk); rst_n = 1'b1; #1;
    chk("first_cycle_ready0", 32'(req0_ready), 0);

    @(negedge clk); #1;
    chk("t1_req0_ready", 32'(req0_ready), 1);
    chk("t1_req1_ready", 32'(req1_ready), 0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("t1_exec_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_exec_ready0", 32'(req0_ready), 0);
    chk("t1_alu_a", 32'(alu_a), 1);
    chk("t1_alu_b", 32'(alu_b), 1);
    @(negedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_rsp_out", 32'(rsp_out), 2);
    chk("t1_rsp_zero", 32'(rsp_zero), 0);
    chk("t1_rsp_carry", 32'(rsp_carry), 0);
    rsp_ready = 1'b1;

    // req1 ADD 11+01 wraps to 00 with carry
    @(negedge clk);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 2'b11; req1_b = 2'b01; req1_sel = OP_ADD;
    #1;
    chk("t2_idle_rsp_valid", 32'(rsp_valid), 0);
    chk("t2_req1_ready", 32'(req1_ready), 1);
    chk("t2_req0_ready", 32'(req0_ready), 0);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("t2_rsp_valid", 32'(rsp_valid), 1);
    chk("t2_rsp_id", 32'(rsp_id), 1);
    chk("t2_rsp_out", 32'(rsp_out), 0);
    chk("t2_rsp_zero", 32'(rsp_zero), 1);
    chk("t2_rsp_carry", 32'(rsp_carry), 1);
    chk("t2_rsp_overflow", 32'(rsp_overflow), 0);
    // Requests raised during RESP must not transfer before IDLE
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 2'b11; req0_b = 2'b01; req0_sel = OP_SUB;
    req1_valid = 1'b1; req1_a = 2'b10; req1_b = 2'b01; req1_sel = OP_OR;

    // Both valid continuously: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t3_grant0", 32'(req0_ready), 32'((i % 2) == 0));
      chk("t3_grant1", 32'(req1_ready), 32'((i % 2) == 1));
      @(negedge clk); #1;
      chk("t3_exec_ready", 32'({req1_ready, req0_ready}), 0);
      chk("t3_exec_rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk); #1;
      chk("t3_rsp_valid", 32'(rsp_valid), 1);
      chk("t3_rsp_id", 32'(rsp_id), 32'(i % 2));
      chk("t3_rsp_out", 32'(rsp_out), ((i % 2) == 0) ? 32'd2 : 32'd3);
    end

    // Backpressure: rsp_ready low for 5 cycles in RESP
    @(negedge clk);
    req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 2'b01; req0_b = 2'b10; req0_sel = OP_ADD;
    #1;
    chk("t4_req0_ready", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 2'b00; req1_b = 2'b00; req1_sel = OP_AND;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t4_hold_valid", 32'(rsp_valid), 1);
      chk("t4_hold_out", 32'(rsp_out), 3);
      chk("t4_hold_id", 32'(rsp_id), 0);
      chk("t4_hold_ready", 32'({req1_ready, req0_ready}), 0);
      chk("t4_hold_alu_a", 32'(alu_a), 1);
    end
    rsp_ready = 1'b1; req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("t4_after_valid", 32'(rsp_valid), 0);
    chk("t4_after_out", 32'(rsp_out), 3);
    chk("t4_idle_alu_a", 32'(alu_a), 1);
    chk("t4_idle_alu_sel", 32'(alu_sel), 0);

    // Invalid opcode 17 times: err_count saturates at 1111
    for (int i = 0; i < 17; i++) begin
      req0_valid = 1'b1; req0_a = 2'b01; req0_b = 2'b10; req0_sel = 3'b100;
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk); #1;
      chk("t5_rsp_error", 32'(rsp_error), 1);
      chk("t5_err_count", 32'(err_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      @(negedge clk); #1;
    end
    chk("t5_err_count_final", 32'(err_count), 15);

    // Reset pulsed during EXEC aborts the operation
    req0_valid = 1'b1; req0_a = 2'b10; req0_b = 2'b11; req0_sel = 3'b100;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("t6_exec_alu_a", 32'(alu_a), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_async_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_async_alu_a", 32'(alu_a), 0);
    chk("t6_async_alu_sel", 32'(alu_sel), 0);
    chk("t6_async_err_count", 32'(err_count), 0);
    chk("t6_async_rsp_error", 32'(rsp_error), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t6_in_rst_valid", 32'(rsp_valid), 0);
    end
    req0_valid = 1'b1; req0_a = 2'b01; req0_b = 2'b01; req0_sel = OP_ADD;
    req1_valid = 1'b1; req1_a = 2'b10; req1_b = 2'b01; req1_sel = OP_OR;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t6_first_cycle_ready", 32'({req1_ready, req0_ready}), 0);
    @(negedge clk); #1;
    chk("t6_no_resp", 32'(rsp_valid), 0);
    chk("t6_ptr_reset_gnt", 32'({req1_ready, req0_ready}), 32'd1);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_rsp_id", 32'(rsp_id), 0);
    chk("t6_rsp_out", 32'(rsp_out), 2);
    chk("t6_err_count", 32'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
